// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: synchronizes and debounces set/clear pushbuttons and turns
// each debounced press into a single-cycle, mutually exclusive S or R pulse.
module sr_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_OFF        = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic dropped
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam int HW = (HOLD_OFF > 1) ? $clog2(HOLD_OFF) : 1;
    localparam logic [HW-1:0] HOLD_LOAD =
        HW'((HOLD_OFF > 0) ? HOLD_OFF - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SET_P,
        CLR_P,
        HOLD
    } state_t;

    // Channel 0 is set, channel 1 is clear.
    logic [1:0]    btn;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    lvl;
    logic [1:0]    lvl_d;
    logic [1:0]    req;
    logic [CW-1:0] cnt [2];

    logic          set_req;
    logic          clr_req;
    logic          any_req;

    state_t        state;
    state_t        next;
    logic [HW-1:0] hold_cnt;

    logic          s_d;
    logic          r_d;
    logic          busy_d;
    logic          conflict_d;
    logic          dropped_d;

    assign btn = {clr_btn, set_btn};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl    <= '0;
            lvl_d  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            lvl_d <= lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    lvl[i] <= ~lvl[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign req     = lvl & ~lvl_d;
    assign set_req = req[0];
    assign clr_req = req[1];
    assign any_req = set_req | clr_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= HOLD_LOAD;
            S        <= 1'b0;
            R        <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            state    <= next;
            hold_cnt <= (state == HOLD) ? hold_cnt - HW'(1) : HOLD_LOAD;
            S        <= s_d;
            R        <= r_d;
            busy     <= busy_d;
            conflict <= conflict_d;
            dropped  <= dropped_d;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (set_req && !clr_req) begin
                    next = SET_P;
                end else if (clr_req && !set_req) begin
                    next = CLR_P;
                end
            end
            SET_P, CLR_P: next = (HOLD_OFF == 0) ? IDLE : HOLD;
            HOLD: begin
                if (hold_cnt == '0) begin
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        s_d        = (next == SET_P);
        r_d        = (next == CLR_P);
        busy_d     = (next != IDLE);
        conflict_d = (state == IDLE) && set_req && clr_req;
        dropped_d  = (state != IDLE) && any_req;
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: directed and randomized checks of sr_cmd_gen against a
// cycle-counting behavioural model of debounce and command acceptance.
module tb_sr_cmd_gen;

    localparam int DB = 4;
    localparam int HO = 2;

    logic clk = 1'b0;
    logic rst;
    logic set_btn;
    logic clr_btn;
    logic S;
    logic R;
    logic busy;
    logic conflict;
    logic dropped;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sr_cmd_gen #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_OFF       (HO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .set_btn (set_btn),
        .clr_btn (clr_btn),
        .S       (S),
        .R       (R),
        .busy    (busy),
        .conflict(conflict),
        .dropped (dropped)
    );

    // Model: per-channel sample pipeline, run length of differing samples,
    // and the last edge of the most recent busy window.
    bit ms1 [2];
    bit ms2 [2];
    bit mlvl [2];
    bit rose [2];
    int run [2];
    int cyc;
    int last_end;
    bit exp_s, exp_r, exp_busy, exp_conf, exp_drop;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms1[i]  = 0;
            ms2[i]  = 0;
            mlvl[i] = 0;
            rose[i] = 0;
            run[i]  = 0;
        end
        cyc      = 0;
        last_end = -100;
        exp_s    = 0;
        exp_r    = 0;
        exp_busy = 0;
        exp_conf = 0;
        exp_drop = 0;
    endtask

    task automatic model_step(input bit sb, input bit cb);
        bit sreq;
        bit creq;
        bit b [2];
        sreq = rose[0];
        creq = rose[1];
        b[0] = sb;
        b[1] = cb;
        exp_s    = 0;
        exp_r    = 0;
        exp_conf = 0;
        exp_drop = 0;
        if (sreq || creq) begin
            if (cyc - 1 > last_end) begin
                if (sreq && creq) begin
                    exp_conf = 1;
                end else begin
                    exp_s    = sreq;
                    exp_r    = creq;
                    last_end = cyc + HO;
                end
            end else begin
                exp_drop = 1;
            end
        end
        exp_busy = (cyc <= last_end);
        for (int i = 0; i < 2; i++) begin
            rose[i] = 0;
            if (ms2[i] != mlvl[i]) begin
                run[i]++;
                if (run[i] == DB) begin
                    mlvl[i] = ~mlvl[i];
                    run[i]  = 0;
                    rose[i] = mlvl[i];
                end
            end else begin
                run[i] = 0;
            end
            ms2[i] = ms1[i];
            ms1[i] = b[i];
        end
        cyc++;
    endtask

    task automatic compare_all();
        chk("S", S, exp_s);
        chk("R", R, exp_r);
        chk("busy", busy, exp_busy);
        chk("conflict", conflict, exp_conf);
        chk("dropped", dropped, exp_drop);
        chk("sr_excl", S & R, 1'b0);
    endtask

    task automatic step(input logic sb, input logic cb);
        set_btn = sb;
        clr_btn = cb;
        @(posedge clk);
        model_step(sb, cb);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        logic sb;
        logic cb;
        rst     = 1'b1;
        set_btn = 1'b0;
        clr_btn = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Single held set press
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0);
            chk("set_lat", S, k == 6);
            chk("set_busy", busy, k >= 6 && k <= 8);
        end
        idle(12);

        // Short clear glitch
        for (int k = 0; k < 15; k++) begin
            step(1'b0, k < 3);
            chk("glitch_R", R, 1'b0);
            chk("glitch_busy", busy, 1'b0);
        end
        idle(4);

        // Simultaneous press
        for (int k = 0; k < 14; k++) begin
            step(1'b1, 1'b1);
            chk("conf_pulse", conflict, k == 6);
            chk("conf_busy", busy, 1'b0);
        end
        idle(12);

        // Clear request lands in hold-off
        for (int k = 0; k < 16; k++) begin
            step(1'b1, k >= 2);
            chk("drop_pulse", dropped, k == 8);
            chk("drop_R", R, 1'b0);
        end
        idle(12);

        // Clear request lands just after hold-off
        for (int k = 0; k < 16; k++) begin
            step(1'b1, k >= 4);
            chk("accept_R", R, k == 10);
            chk("accept_drop", dropped, 1'b0);
        end
        idle(12);

        // Reset during the S pulse
        for (int k = 0; k <= 6; k++) step(1'b1, 1'b0);
        chk("pre_rst_S", S, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_S", S, 1'b0);
        chk("rst_async_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            step(1'b1, 1'b0);
            chk("rst_resume", S, k == 6);
        end
        idle(12);

        // Random bouncing
        sb = 1'b0;
        cb = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(7) == 0) sb = ~sb;
            if ($urandom_range(7) == 0) cb = ~cb;
            step(sb, cb);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Front-end command generator that sits directly upstream of the clocked SR flip-flop and drives its S and R inputs. It synchronizes and debounces two raw pushbuttons (set and clear), then converts each debounced press into a single-cycle S or R pulse. It guarantees that S and R are never asserted together, enforces a hold-off gap between commands, and flags simultaneous or dropped presses.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive cycles a synchronized input must stay at a new level before the debounced level changes; legal range ≥1.
- HOLD_OFF, 2, idle cycles after each S/R pulse during which new requests are rejected; legal range ≥0 (0 = no hold-off).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- set_btn  in  1  raw, asynchronous set pushbutton; active-high.
- clr_btn  in  1  raw, asynchronous clear pushbutton; active-high.
- S  out  1  registered set pulse to the SR flip-flop.
- R  out  1  registered reset pulse to the SR flip-flop.
- busy  out  1  high while a pulse or hold-off is in progress.
- conflict  out  1  one-cycle pulse when set and clear requests coincide.
- dropped  out  1  one-cycle pulse when a request arrives while busy.

## Operation
- Synchronizer: each button passes through its own 2-flop synchronizer.
- Debouncer: each channel holds a debounced level and a counter.
  - The counter clears whenever the synchronized value equals the debounced level.
  - Otherwise the counter increments.
  - When the synchronized value has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced level flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no change.
- Request: a 0→1 transition of a debounced level creates a one-cycle request (set_req or clr_req). A 1→0 transition creates nothing.
- FSM states are IDLE, SET_P, CLR_P and HOLD.
  - IDLE, set_req only → SET_P.
  - IDLE, clr_req only → CLR_P.
  - IDLE, both requests in the same cycle → conflict=1 for one cycle; stay in IDLE; no S or R.
  - SET_P: S=1 for exactly one cycle, then go to HOLD (or IDLE if HOLD_OFF=0).
  - CLR_P: R=1 for exactly one cycle, then go to HOLD (or IDLE if HOLD_OFF=0).
  - HOLD: lasts exactly HOLD_OFF cycles, then go to IDLE.
- busy=1 in SET_P, CLR_P and HOLD.
- Any request arriving in SET_P, CLR_P or HOLD is discarded. It is not queued, and dropped=1 for that cycle. If both requests arrive while busy, dropped pulses once.
- Invariant: S&R is never 1 in any cycle, including across reset.
- All outputs are registered. There is no combinational path from any input to any output.

## Timing
- Reset (async, immediate): S=0, R=0, busy=0, conflict=0, dropped=0. State=IDLE. Synchronizer flops, debounced levels and counters all clear to 0.
- Reset mid-pulse: S and R drop immediately. No resumption after reset release.
- Button held through reset release: the debounced level rises after the normal latency and generates one command.
- Latency: let a button first sample high at clock edge 0 and stay high. Then S (or R) is high for exactly one cycle, between edge 2+DEBOUNCE_CYCLES and edge 3+DEBOUNCE_CYCLES. With default DEBOUNCE_CYCLES=4, that is edges 6→7.
- busy rises together with S/R. It stays high for 1+HOLD_OFF cycles.
- Next accepted request: the earliest request accepted after a pulse is the one that arrives HOLD_OFF+1 cycles after the pulse cycle.
- conflict and dropped assert in the same cycle the request is evaluated, which is the cycle in which an S/R pulse would otherwise have started.
- Holding a button continuously yields exactly one pulse. Release plus re-press requires a full debounce in each direction.

## Test plan
- Reset, then raise set_btn at edge 0 and hold it (defaults) → S=1 only during edges 6→7; R=0 throughout; busy=1 for 3 cycles; no further S while set_btn stays high.
- Glitch on clr_btn high for 3 cycles (DEBOUNCE_CYCLES=4), then low → R, busy, conflict and dropped stay 0 for the whole run.
- Raise set_btn and clr_btn on the same edge and hold both → conflict=1 for one cycle at edge 6; S=R=0; busy=0.
- Debounced set press, then a clr press whose request lands 1 cycle after the S pulse (in HOLD) → dropped=1 for one cycle; R never asserts. Repeat with the request 3 cycles after the S pulse → R asserts for one cycle.
- Assert rst during the S pulse cycle → S falls without waiting for a clock edge. After release with set_btn still held, S pulses again exactly 2+DEBOUNCE_CYCLES edges after the first sampling edge.
- Randomized button bouncing for 10k cycles with an S&R assertion check → no cycle with S=R=1; each S/R pulse is exactly one cycle wide.
